// File: rtl/rr_arbiter_n.sv
// rr_arbiter_n: N-way round-robin bus arbiter. A granted master keeps the bus
// while it requests. A maximum-hold timeout forces handover to waiting masters.
module rr_arbiter_n #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int IDX_W    = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             preempt
);

  localparam int               HW        = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0]    HOLD_SAT  = HW'(MAX_HOLD);
  localparam logic [HW-1:0]    HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [IDX_W-1:0] PTR_RST   = IDX_W'(N - 1);
  localparam logic [N-1:0]     ONE_HOT0  = N'(1);

  // Returns {found, index} of the first set bit of r at or after p+1, wrapping.
  function automatic logic [IDX_W:0] rr_search(input logic [N-1:0] r,
                                                input logic [IDX_W-1:0] p);
    logic [IDX_W:0] res;
    int             idx;
    res = '0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(p) + k) % N;
      if (r[idx]) begin
        res = {1'b1, IDX_W'(idx)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N-1:0] oh);
    logic [IDX_W-1:0] res;
    res = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) begin
        res = res | IDX_W'(i);
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  logic [N-1:0]     gnt_r, gnt_nxt_s;
  logic [IDX_W-1:0] ptr_r, ptr_nxt_s;
  logic [HW-1:0]    hold_r, hold_nxt_s;
  logic             preempt_r, preempt_nxt_s;
  logic [N-1:0]     others_s;
  logic [IDX_W:0]   pick_all_s, pick_oth_s;
  logic             owner_req_s, timeout_s;

  assign others_s    = req & ~gnt_r;
  assign owner_req_s = |(req & gnt_r);
  assign pick_all_s  = rr_search(req, ptr_r);
  assign pick_oth_s  = rr_search(others_s, ptr_r);
  // hold_r can sit saturated at MAX_HOLD, so the timeout uses >= rather than ==.
  assign timeout_s   = (MAX_HOLD != 0) && (hold_r >= HOLD_LAST) && (|others_s);

  // Next-state: arbitrate from idle or on release, preempt on timeout, else hold.
  always_comb begin
    gnt_nxt_s     = gnt_r;
    ptr_nxt_s     = ptr_r;
    hold_nxt_s    = hold_r;
    preempt_nxt_s = 1'b0;
    if (!owner_req_s) begin
      if (pick_all_s[IDX_W]) begin
        gnt_nxt_s  = ONE_HOT0 << pick_all_s[IDX_W-1:0];
        ptr_nxt_s  = pick_all_s[IDX_W-1:0];
        hold_nxt_s = '0;
      end else begin
        gnt_nxt_s  = '0;
        hold_nxt_s = '0;
      end
    end else if (timeout_s) begin
      gnt_nxt_s     = ONE_HOT0 << pick_oth_s[IDX_W-1:0];
      ptr_nxt_s     = pick_oth_s[IDX_W-1:0];
      hold_nxt_s    = '0;
      preempt_nxt_s = 1'b1;
    end else begin
      if (hold_r != HOLD_SAT) begin
        hold_nxt_s = hold_r + 1'b1;
      end else begin
        hold_nxt_s = hold_r;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_r     <= '0;
      ptr_r     <= PTR_RST;
      hold_r    <= '0;
      preempt_r <= 1'b0;
    end else begin
      gnt_r     <= gnt_nxt_s;
      ptr_r     <= ptr_nxt_s;
      hold_r    <= hold_nxt_s;
      preempt_r <= preempt_nxt_s;
    end
  end

  assign gnt       = gnt_r;
  assign gnt_valid = |gnt_r;
  assign gnt_idx   = onehot_to_idx(gnt_r);
  assign preempt   = preempt_r;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Scoreboard bench for rr_arbiter_n: four configurations share one stimulus
// stream and are compared against an integer-level round-robin model.
module tb_rr_arbiter_n;

  localparam int NI = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;

  logic [3:0] g0, g1, g2;
  logic [7:0] g3;
  logic       v0, v1, v2, v3;
  logic [1:0] i0, i1, i2;
  logic [2:0] i3;
  logic       p0, p1, p2, p3;

  always #5 clk = ~clk;

  rr_arbiter_n #(.N(4), .MAX_HOLD(8)) d0 (.clk(clk), .rst(rst), .req(req[3:0]),
    .gnt(g0), .gnt_valid(v0), .gnt_idx(i0), .preempt(p0));
  rr_arbiter_n #(.N(4), .MAX_HOLD(0)) d1 (.clk(clk), .rst(rst), .req(req[3:0]),
    .gnt(g1), .gnt_valid(v1), .gnt_idx(i1), .preempt(p1));
  rr_arbiter_n #(.N(4), .MAX_HOLD(4)) d2 (.clk(clk), .rst(rst), .req(req[3:0]),
    .gnt(g2), .gnt_valid(v2), .gnt_idx(i2), .preempt(p2));
  rr_arbiter_n #(.N(8), .MAX_HOLD(3)) d3 (.clk(clk), .rst(rst), .req(req),
    .gnt(g3), .gnt_valid(v3), .gnt_idx(i3), .preempt(p3));

  // Expected entry per instance: [11:9] idx, [8] preempt, [7:0] gnt.
  typedef struct packed {
    logic             rst;
    logic [7:0]       req;
    logic [3:0][11:0] e;
  } ent_t;

  ent_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;

  // Reference model state: owner (-1 = idle), last granted, cycles held so far.
  int owner [NI];
  int last  [NI];
  int held  [NI];

  function automatic int n_of(int k);
    return (k == 3) ? 8 : 4;
  endfunction

  function automatic int m_of(int k);
    case (k)
      0:       return 8;
      1:       return 0;
      2:       return 4;
      default: return 3;
    endcase
  endfunction

  function automatic int rr_pick(logic [7:0] r, int from, int n);
    for (int d = 1; d <= n; d++) begin
      if (r[(from + d) % n]) return (from + d) % n;
    end
    return -1;
  endfunction

  function automatic logic [11:0] model_step(int k, logic rs, logic [7:0] r_in);
    int         n, m, pick;
    logic [7:0] r, others, g;
    logic       pre;
    n   = n_of(k);
    m   = m_of(k);
    pre = 1'b0;
    r   = r_in & ((n == 8) ? 8'hFF : 8'h0F);
    if (rs) begin
      owner[k] = -1;
      last[k]  = n - 1;
      held[k]  = 0;
    end else if (owner[k] < 0 || !r[owner[k]]) begin
      pick     = rr_pick(r, last[k], n);
      owner[k] = pick;
      held[k]  = (pick >= 0) ? 1 : 0;
      if (pick >= 0) last[k] = pick;
    end else begin
      others = r;
      others[owner[k]] = 1'b0;
      if (m > 0 && held[k] >= m && others != 8'h00) begin
        pick     = rr_pick(others, last[k], n);
        owner[k] = pick;
        last[k]  = pick;
        held[k]  = 1;
        pre      = 1'b1;
      end else begin
        held[k]++;
      end
    end
    g = (owner[k] >= 0) ? (8'h01 << owner[k]) : 8'h00;
    return {((owner[k] >= 0) ? 3'(owner[k]) : 3'd0), pre, g};
  endfunction

  task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 30)
        $display("FAIL %s inst%0d cycle %0d: got %0h expected %0h", name, k, cyc, act, exp);
    end
  endtask

  task automatic step(logic r_rst, logic [7:0] r_req);
    ent_t en;
    @(negedge clk);
    rst    = r_rst;
    req    = r_req;
    en.rst = r_rst;
    en.req = r_req;
    for (int k = 0; k < NI; k++) en.e[k] = model_step(k, r_rst, r_req);
    q.push_back(en);
  endtask

  task automatic hold_req(logic [7:0] r, int cycles);
    for (int c = 0; c < cycles; c++) step(1'b0, r);
  endtask

  // Monitor: pops one expectation per clock edge and compares all instances.
  logic [7:0] ag [NI];
  logic       av [NI];
  logic [2:0] ai [NI];
  logic       ap [NI];
  int         wait_cnt [8];
  ent_t       cur;

  initial begin
    for (int i = 0; i < 8; i++) wait_cnt[i] = 0;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        cur = q.pop_front();
        cyc++;
        ag[0] = {4'h0, g0}; av[0] = v0; ai[0] = {1'b0, i0}; ap[0] = p0;
        ag[1] = {4'h0, g1}; av[1] = v1; ai[1] = {1'b0, i1}; ap[1] = p1;
        ag[2] = {4'h0, g2}; av[2] = v2; ai[2] = {1'b0, i2}; ap[2] = p2;
        ag[3] = g3;         av[3] = v3; ai[3] = i3;         ap[3] = p3;
        for (int k = 0; k < NI; k++) begin
          chk("gnt",       k, 32'(ag[k]), 32'(cur.e[k][7:0]));
          chk("gnt_valid", k, 32'(av[k]), 32'(|cur.e[k][7:0]));
          chk("gnt_idx",   k, 32'(ai[k]), 32'(cur.e[k][11:9]));
          chk("preempt",   k, 32'(ap[k]), 32'(cur.e[k][8]));
          chk("onehot0",   k, 32'($onehot0(ag[k])), 32'd1);
          chk("gnt_without_req", k, 32'(ag[k] & ~cur.req), 32'd0);
        end
        for (int i = 0; i < 8; i++) begin
          if (cur.rst || !cur.req[i] || g3[i]) wait_cnt[i] = 0;
          else wait_cnt[i]++;
          chk("max_wait", 3, 32'(wait_cnt[i] > 21), 32'd0);
        end
      end
    end
  end

  // Stimulus: directed scenarios followed by random traffic.
  initial begin
    logic [7:0] r;
    for (int k = 0; k < NI; k++) begin
      owner[k] = -1;
      last[k]  = n_of(k) - 1;
      held[k]  = 0;
    end
    // All four requesting continuously: rotation with timeouts.
    step(1'b1, 8'h00);
    step(1'b1, 8'h00);
    hold_req(8'h0F, 40);
    // Single requester holds indefinitely, then releases to idle.
    step(1'b1, 8'h00);
    hold_req(8'h04, 20);
    hold_req(8'h00, 3);
    // Owner 1 releases while others wait: handover with no idle cycle.
    step(1'b1, 8'h00);
    hold_req(8'h02, 1);
    hold_req(8'h0B, 5);
    hold_req(8'h09, 3);
    hold_req(8'h01, 3);
    // Owner 2 alone, then master 0 arrives mid-hold.
    step(1'b1, 8'h00);
    hold_req(8'h04, 3);
    hold_req(8'h05, 6);
    hold_req(8'h00, 2);
    // Reset while owner 3 is active under full contention.
    step(1'b1, 8'h00);
    hold_req(8'h08, 1);
    hold_req(8'h0F, 2);
    step(1'b1, 8'h0F);
    hold_req(8'h0F, 4);
    // Random traffic with sticky requests and rare resets.
    r = 8'h00;
    for (int c = 0; c < 10000; c++) begin
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      end
      step(($urandom_range(0, 999) == 0) ? 1'b1 : 1'b0, r);
    end
    for (int t = 0; t < 5 && q.size() != 0; t++) @(negedge clk);
    chk("scoreboard_drain", 0, 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
